// File: rtl/ne_fp_add_arb.sv
// ne_fp_add_arb: round-robin scheduler in front of one shared, pipelined
// multi-mode adder. Each request is tagged with its requester ID and tracked
// through the adder's fixed latency. Results are then returned in issue order
// through a credit-protected response FIFO.
module ne_fp_add_arb #(
    parameter int NREQ      = 4,
    parameter int BWA       = 40,
    parameter int BWZ       = 41,
    parameter int ADD_LAT   = 1,
    parameter int RSP_DEPTH = 4,
    parameter int IDW       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*BWA-1:0]   req_a,
    input  logic [NREQ*BWA-1:0]   req_b,
    input  logic [NREQ*3-1:0]     req_mode,
    output logic [BWA-1:0]        add_a,
    output logic [BWA-1:0]        add_b,
    output logic [2:0]            add_mode,
    input  logic [BWZ-1:0]        add_z,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [BWZ-1:0]        rsp_z,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + ADD_LAT + 2) + 1;

    logic [IDW-1:0]               ptr;
    logic [IDW-1:0]               gnt;
    logic                         gnt_found;
    logic                         issue_ok;
    logic                         hs;
    logic [2:0]                   gmode;
    logic                         mode_ok;

    logic [ADD_LAT:0]             vld_pipe;
    logic [ADD_LAT:0]             err_pipe;
    logic [ADD_LAT:0][IDW-1:0]    id_pipe;
    logic [CW-1:0]                infl_cnt;

    logic [IDW-1:0]               mem_id  [RSP_DEPTH];
    logic [BWZ-1:0]               mem_z   [RSP_DEPTH];
    logic                         mem_err [RSP_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [CW-1:0]                fifo_cnt;
    logic                         push;
    logic                         pop;

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_valid[(int'(ptr) + i) % NREQ]) begin
                gnt_found = 1'b1;
                gnt       = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // Count operations still travelling through the adder
    always_comb begin
        infl_cnt = '0;
        for (int k = 0; k <= ADD_LAT; k++)
            infl_cnt = infl_cnt + CW'(vld_pipe[k]);
    end

    // Issue only when a slot is reserved in the FIFO for the eventual result,
    // so a response can never be dropped; nothing is accepted while in reset.
    assign issue_ok  = rst_n && ((fifo_cnt + infl_cnt) < CW'(RSP_DEPTH));
    assign hs        = gnt_found && issue_ok;
    assign req_ready = hs ? (NREQ'(1) << gnt) : '0;
    assign gmode     = req_mode[int'(gnt)*3 +: 3];
    assign mode_ok   = (gmode == 3'b100) || (gmode == 3'b010) || (gmode == 3'b001);

    // Registered adder operands and pointer advance on each handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_mode <= 3'b000;
        end else begin
            // idle and illegal-mode cycles present mode 000 so the adder stays quiet
            add_mode <= (hs && mode_ok) ? gmode : 3'b000;
            if (hs) begin
                add_a <= req_a[int'(gnt)*BWA +: BWA];
                add_b <= req_b[int'(gnt)*BWA +: BWA];
                ptr   <= (int'(gnt) == NREQ-1) ? '0 : gnt + 1'b1;
            end
        end
    end

    // Tag pipeline: stage 0 lines up with the cycle the operands reach the adder
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= hs;
            err_pipe[0] <= hs && !mode_ok;
            id_pipe[0]  <= gnt;
            for (int k = 1; k <= ADD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                err_pipe[k] <= err_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
            end
        end
    end

    assign push = vld_pipe[ADD_LAT];
    assign pop  = rsp_valid && rsp_ready;

    // FIFO storage; an illegal-mode result is zeroed on capture
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]  <= id_pipe[ADD_LAT];
            mem_z[wr_ptr]   <= err_pipe[ADD_LAT] ? '0 : add_z;
            mem_err[wr_ptr] <= err_pipe[ADD_LAT];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == AW'(RSP_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == AW'(RSP_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rsp_valid = (fifo_cnt != '0);
    assign rsp_id    = mem_id[rd_ptr];
    assign rsp_z     = mem_z[rd_ptr];
    assign rsp_err   = mem_err[rd_ptr];
    assign busy      = (|vld_pipe) || rsp_valid;

    // The credit scheme must make an overflowing push unreachable
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push && fifo_cnt == CW'(RSP_DEPTH)));

endmodule
